regfile_2r1w: RTL

- Parametrised multi-register file that replaces banks of individual 16-bit registers in the RISC16 datapath.
- One write port and two independently enabled read ports (A and B) feed the ALU operand buses.
- Read outputs are registered with write-to-read bypass.
- A per-register busy scoreboard tracks outstanding multicycle results (memory loads) so that control logic can stall on hazards.

---
 rtl/regfile_2r1w.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with registered, write-first
// bypassed read ports and a per-register busy scoreboard for load hazards.
module regfile_2r1w #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raA,
  input  logic             reA,
  input  logic [AW-1:0]    raB,
  input  logic             reB,
  input  logic             set_busy,
  input  logic [AW-1:0]    busy_addr,
  output logic [WIDTH-1:0] DA,
  output logic [WIDTH-1:0] DB,
  output logic             busyA,
  output logic             busyB
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             wr_ok;
  logic             set_ok;

  // A register accepts writes/busy sets only if it exists and is not the
  // hardwired zero register.
  function automatic logic writable(input logic [AW-1:0] a);
    writable = ({{(32-AW){1'b0}}, a} < DEPTH) && !(ZERO_R0 && (a == '0));
  endfunction

  assign wr_ok  = we && writable(waddr);
  assign set_ok = set_busy && writable(busy_addr);

  // NOTE: always_comb assigns every output a default first so no latch is
  // inferred on paths where no branch matches (e.g. out-of-range addresses).
  always_comb begin
    rd_a  = '0;
    rd_b  = '0;
    busyA = 1'b0;
    busyB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raA == AW'(i)) begin
        rd_a  = mem[i];
        busyA = busy[i];
      end
      if (raB == AW'(i)) begin
        rd_b  = mem[i];
        busyB = busy[i];
      end
    end
    if (wr_ok && (waddr == raA)) rd_a = wdata;
    if (wr_ok && (waddr == raB)) rd_b = wdata;
    if (ZERO_R0 && (raA == '0)) rd_a = '0;
    if (ZERO_R0 && (raB == '0)) rd_b = '0;
  end

  // Clear on write first, then set, so a same-cycle set wins.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok  && (waddr     == AW'(i))) busy_next[i] = 1'b0;
      if (set_ok && (busy_addr == AW'(i))) busy_next[i] = 1'b1;
    end
  end

  // NOTE: the storage array is reset explicitly because every register must
  // read as zero after reset; this costs a reset mux per bit and rules out RAM.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
      DA   <= '0;
      DB   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (waddr == AW'(i))) mem[i] <= wdata;
      end
      busy <= busy_next;
      if (reA) DA <= rd_a;
      if (reB) DB <= rd_b;
    end
  end

endmodule
